dither_output_packer: RTL

//  Downstream of the dithering pixel algorithm unit. After a frame is dithered in pixel SRAM,

---
 rtl/dither_output_packer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dither_output_packer.sv
// Reads a dithered frame from pixel SRAM, thresholds each pixel to 1 bit and streams packed bytes.
// Optional trailing XOR checksum byte: define DITHER_OUT_CHECKSUM_EN.
module dither_output_packer #(
    parameter int unsigned IMAGEX           = 64,
    parameter int unsigned IMAGEY           = 64,
    parameter int unsigned IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int unsigned IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int unsigned RGB_SIZE         = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    output logic [15:0]         sram_addr_o,
    output logic                sram_rden_o,
    input  logic [RGB_SIZE-1:0] sram_q_i,
    output logic [7:0]          out_byte_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    // One extra bit so the final count equals IMAGE_SIZE instead of wrapping to zero.
    localparam int unsigned CntW = IMAGE_ADDR_WIDTH + 1;
    localparam logic [CntW-1:0] PixEnd = CntW'(IMAGE_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapt,
        StOut,
`ifdef DITHER_OUT_CHECKSUM_EN
        StCsum,
`endif
        StFin
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] pix_cnt_q, pix_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
`ifdef DITHER_OUT_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic unused_sram_bits;
    assign unused_sram_bits = ^sram_q_i[RGB_SIZE-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pix_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef DITHER_OUT_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
`ifdef DITHER_OUT_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
`ifdef DITHER_OUT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        sram_addr_o = '0;
        sram_rden_o = 1'b0;
        out_byte_o  = '0;
        out_valid_o = 1'b0;
        done_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    pix_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
`ifdef DITHER_OUT_CHECKSUM_EN
                    csum_d    = '0;
`endif
                    state_d   = StRead;
                end
            end
            StRead: begin
                sram_rden_o = 1'b1;
                sram_addr_o = 16'(pix_cnt_q[IMAGE_ADDR_WIDTH-1:0]);
                state_d     = StCapt;
            end
            StCapt: begin
                // MSB of the pixel is the >= half-scale threshold.
                shift_d   = {shift_q[6:0], sram_q_i[RGB_SIZE-1]};
                pix_cnt_d = pix_cnt_q + CntW'(1);
                bit_cnt_d = bit_cnt_q + 3'd1;
                state_d   = (bit_cnt_q == 3'd7) ? StOut : StRead;
            end
            StOut: begin
                out_valid_o = 1'b1;
                out_byte_o  = shift_q;
                if (out_ready_i) begin
`ifdef DITHER_OUT_CHECKSUM_EN
                    csum_d  = csum_q ^ shift_q;
                    state_d = (pix_cnt_q == PixEnd) ? StCsum : StRead;
`else
                    state_d = (pix_cnt_q == PixEnd) ? StFin : StRead;
`endif
                end
            end
`ifdef DITHER_OUT_CHECKSUM_EN
            StCsum: begin
                out_valid_o = 1'b1;
                out_byte_o  = csum_q;
                if (out_ready_i) begin
                    state_d = StFin;
                end
            end
`endif
            StFin: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o = (state_q != StIdle) && (state_q != StFin);

endmodule
